// File: rtl/clock_divider_multi_if.sv
// ---------------------------------------------------------------------------
// clock_divider_multi_if
//
// Bundles the control and status signals of the multi-channel clock divider.
//
//   ch_en       : per-channel run enable                      (master -> slave)
//   sync_clr    : one-cycle phase-align request               (master -> slave)
//   wr_en       : divisor write strobe                        (master -> slave)
//   wr_ch       : channel addressed by the write              (master -> slave)
//   wr_div      : new divisor value                           (master -> slave)
//   clk_out     : divided level waveforms                     (slave -> master)
//   tick        : one-cycle pulse on the last count of a period (slave -> master)
//   div_pending : a written divisor waits for its boundary    (slave -> master)
//   cfg_err     : one-cycle pulse when a write is rejected    (slave -> master)
// ---------------------------------------------------------------------------
interface clock_divider_multi_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 28
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ch_en;
  logic              sync_clr;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_pending;
  logic              cfg_err;

  // The controller drives configuration and reads back status.
  modport master (
    output ch_en, sync_clr, wr_en, wr_ch, wr_div,
    input  clk_out, tick, div_pending, cfg_err
  );

  // The divider consumes configuration and produces status.
  modport slave (
    input  ch_en, sync_clr, wr_en, wr_ch, wr_div,
    output clk_out, tick, div_pending, cfg_err
  );

endinterface

// File: rtl/clock_divider_multi.sv
// ---------------------------------------------------------------------------
// clock_divider_multi
//
// Runtime-programmable multi-channel clock divider. Each channel counts
// 0..div-1 and produces a registered level waveform that is high for the
// first floor(div/2) counts, plus a one-cycle tick on the last count.
// Divisor writes are staged in a pending register and only take effect at a
// period boundary, a phase-align clear, or while the channel is disabled, so
// a running waveform never sees a truncated or stretched period.
// Outputs are intended for slow logic and LEDs, not for clock trees.
//
// Ports:
//   i_clk_in : system clock, all logic on the rising edge
//   i_reset  : synchronous active-high reset
//   bus      : clock_divider_multi_if slave modport (enables, clear, divisor
//              writes in; clk_out, tick, div_pending, cfg_err out)
// ---------------------------------------------------------------------------
module clock_divider_multi #(
  parameter int                        NUM_CH   = 3,
  parameter int                        CNT_W    = 28,
  parameter logic [NUM_CH*CNT_W-1:0]   DEF_DIVS = {28'd8, 28'd16, 28'd32}
) (
  input  logic                  i_clk_in,
  input  logic                  i_reset,
  clock_divider_multi_if.slave  bus
);

  localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0]    NUM_CH_V = (CH_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_divAct [NUM_CH];
  logic [CNT_W-1:0]  r_pend   [NUM_CH];
  logic [NUM_CH-1:0] r_pendValid;
  logic [NUM_CH-1:0] r_clkOut;
  logic [NUM_CH-1:0] r_tick;
  logic              r_cfgErr;

  logic              w_wrOk;
  logic [NUM_CH-1:0] w_boundary;
  logic [NUM_CH-1:0] w_restart;
  logic [NUM_CH-1:0] w_wrHit;

  // Decode the write and, per channel, whether this cycle ends the period.
  // A restart happens on the natural boundary, on a phase-align clear, or
  // whenever the channel is disabled; every restart is also the only moment
  // a pending divisor is allowed to become active.
  always_comb begin
    w_wrOk     = bus.wr_en && ({1'b0, bus.wr_ch} < NUM_CH_V) && (bus.wr_div >= TWO);
    w_boundary = '0;
    w_restart  = '0;
    w_wrHit    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_boundary[i] = (r_cnt[i] == (r_divAct[i] - ONE));
      w_restart[i]  = ~bus.ch_en[i] | bus.sync_clr | w_boundary[i];
      w_wrHit[i]    = w_wrOk && (bus.wr_ch == CH_W'(i));
    end
  end

  // Per-channel counter, active/pending divisor and registered outputs.
  // The pending load happens before the write capture in the same cycle, so
  // a write landing on a restart cycle is not consumed by that restart: the
  // older pending value (if any) loads now and the new one waits for the
  // next restart.
  always_ff @(posedge i_clk_in) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]    <= '0;
        r_divAct[i] <= DEF_DIVS[i*CNT_W +: CNT_W];
        r_pend[i]   <= '0;
      end
      r_pendValid <= '0;
      r_clkOut    <= '0;
      r_tick      <= '0;
      r_cfgErr    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_clkOut[i] <= bus.ch_en[i] & (r_cnt[i] < (r_divAct[i] >> 1));
        r_tick[i]   <= bus.ch_en[i] & w_boundary[i] & ~bus.sync_clr;

        if (w_restart[i]) begin
          r_cnt[i] <= '0;
          if (r_pendValid[i]) begin
            r_divAct[i]    <= r_pend[i];
            r_pendValid[i] <= 1'b0;
          end
        end else begin
          r_cnt[i] <= r_cnt[i] + ONE;
        end

        if (w_wrHit[i]) begin
          r_pend[i]      <= bus.wr_div;
          r_pendValid[i] <= 1'b1;
        end
      end
      r_cfgErr <= bus.wr_en & ~w_wrOk;
    end
  end

  // Status outputs come straight from registers.
  assign bus.clk_out     = r_clkOut;
  assign bus.tick        = r_tick;
  assign bus.div_pending = r_pendValid;
  assign bus.cfg_err     = r_cfgErr;

endmodule
